// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: sequential/branch/RTI next-PC selection, stall hold and a
// drain-then-vector interrupt entry. Define PC_INT_PENDING_EN to latch requests that miss an edge.
module pc_sequencer #(
  parameter int unsigned             WIDTH            = 32,
  parameter logic [WIDTH-1:0]        RESET_VECTOR     = WIDTH'(32),
  parameter logic [WIDTH-1:0]        INT_VECTOR       = '0,
  parameter int unsigned             INT_DRAIN_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_long_instr,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_rti,
  input  logic             i_interrupt,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_saved_pc,
  output logic             o_fetch_valid,
  output logic             o_int_ack
);

  localparam int unsigned CntW = (INT_DRAIN_CYCLES > 1) ? $clog2(INT_DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StVector} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  saved_q, saved_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [WIDTH-1:0]  npc;
  logic              int_req;
  logic              eligible;

`ifdef PC_INT_PENDING_EN
  logic pend_q, pend_d;
  assign int_req = i_interrupt | pend_q;
`else
  assign int_req = i_interrupt;
`endif

  // A branch overrides a stall, so a stalled branch may still take an interrupt.
  assign eligible = ~i_stall | i_branch_taken;

  always_comb begin
    if (i_branch_taken) begin
      npc = i_branch_target;
    end else if (i_rti) begin
      npc = saved_q;
    end else if (i_stall) begin
      npc = pc_q;
    end else begin
      npc = pc_q + (i_long_instr ? WIDTH'(2) : WIDTH'(1));
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
`ifdef PC_INT_PENDING_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      StRun: begin
        if (int_req && eligible) begin
          saved_d = npc;
          cnt_d   = CntW'(INT_DRAIN_CYCLES - 1);
          state_d = StDrain;
`ifdef PC_INT_PENDING_EN
          pend_d  = 1'b0;
`endif
        end else begin
          pc_d = npc;
`ifdef PC_INT_PENDING_EN
          if (i_interrupt) pend_d = 1'b1;
`endif
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StVector;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
`ifdef PC_INT_PENDING_EN
        if (i_interrupt) pend_d = 1'b1;
`endif
      end
      StVector: begin
        pc_d    = INT_VECTOR;
        ack_d   = 1'b1;
        state_d = StRun;
`ifdef PC_INT_PENDING_EN
        if (i_interrupt) pend_d = 1'b1;
`endif
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      saved_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
`ifdef PC_INT_PENDING_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
`ifdef PC_INT_PENDING_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign o_pc          = pc_q;
  assign o_saved_pc    = saved_q;
  assign o_int_ack     = ack_q;
  assign o_fetch_valid = (state_q == StRun);

endmodule
